// File: rtl/toggle_handshake_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : toggle_handshake_rx_if
// Brief    : Bundle of toggle-handshake request, consumer and status signals.
// Revision : 1.0 - initial release
// ============================================================================
interface toggle_handshake_rx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             req_tgl;
  logic [WIDTH-1:0] req_data;
  logic             ack_tgl;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] event_count;
  logic             overrun;

  modport master (
    output req_tgl, req_data, out_ready,
    input  ack_tgl, out_valid, out_data, event_count, overrun
  );

  modport slave (
    input  req_tgl, req_data, out_ready,
    output ack_tgl, out_valid, out_data, event_count, overrun
  );
endinterface
`default_nettype wire

// File: rtl/toggle_handshake_rx.sv
`default_nettype none
// ============================================================================
// Module   : toggle_handshake_rx
// Brief    : Receive end of the two-phase toggle handshake with valid/ready out.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_handshake_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  wire logic          clock,
  input  wire logic          reset,
  toggle_handshake_rx_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_req_seen;
  logic                   r_ack_tgl;
  logic                   r_out_valid;
  logic [WIDTH-1:0]       r_out_data;
  logic [CNT_W-1:0]       r_event_count;
  logic                   r_overrun;
  logic                   w_req_sync;
  logic                   w_capture;
  logic                   w_accept;

  assign w_req_sync = r_sync[SYNC_STAGES-1];

  // Only the request level crosses domains; req_data is held stable by the
  // initiator until our ack, so it is sampled directly at capture time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req_tgl};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_sync != r_req_seen) begin
          w_capture   = 1'b1;
          w_state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.out_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_req_seen    <= 1'b0;
      r_ack_tgl     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_event_count <= '0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_req_seen  <= w_req_sync;
        r_out_data  <= bus.req_data;
        r_out_valid <= 1'b1;
      end
      if (w_accept) begin
        r_out_valid   <= 1'b0;
        r_ack_tgl     <= ~r_ack_tgl;
        r_event_count <= r_event_count + CNT_W'(1);
      end
      // A level change while still holding the previous payload means the
      // initiator did not wait for our ack.
      if ((r_state == S_VALID) && (w_req_sync != r_req_seen)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.ack_tgl     = r_ack_tgl;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.event_count = r_event_count;
  assign bus.overrun     = r_overrun;

endmodule
`default_nettype wire

// File: doc/toggle_handshake_rx.md
Name: toggle_handshake_rx

Overview:
- Responder (receive end) of the team's two-phase toggle handshake. The initiator side is built on the toggle flip-flop and signals each request by inverting `req_tgl`.
- This block synchronizes `req_tgl` into the local clock and detects each level change. For each change it captures `req_data`, presents it on a valid/ready output and returns completion by inverting `ack_tgl`.
- It sits between a toggle-based initiator, which may be in another clock domain, and a local consumer.

Parameters:
- WIDTH, 8, width of req_data / out_data.
- SYNC_STAGES, 2, flops in the req_tgl synchronizer (legal 2..4).
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_tgl  in  1  request level; every inversion is one request.
- req_data  in  WIDTH  payload; initiator holds it stable from the req_tgl inversion until the matching ack_tgl inversion.
- ack_tgl  out  1  acknowledge level; inverts once per completed transfer.
- out_valid  out  1  captured payload available.
- out_data  out  WIDTH  captured payload.
- out_ready  in  1  consumer accepts out_data when high with out_valid.
- event_count  out  CNT_W  number of completed transfers, wraps modulo 2^CNT_W.
- overrun  out  1  sticky: req_tgl inverted again before the pending request was acknowledged.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer) forces:
  - sync chain = 0, req_seen = 0, ack_tgl = 0;
  - out_valid = 0, out_data = 0, event_count = 0, overrun = 0;
  - state = IDLE.
  - Any pending transfer is dropped silently.
- Reset pairing: the initiator must be reset together with this block. If req_tgl = 1 at reset release, one request is detected, by design.
- Synchronizer:
  - sync[0] <= req_tgl; sync[i] <= sync[i-1].
  - Define req_sync = sync[SYNC_STAGES-1].
  - req_data is NOT synchronized; it is captured only on detection.
- FSM, two states, IDLE and VALID:
  - IDLE: if req_sync != req_seen, then on that edge: req_seen <= req_sync, out_data <= req_data, out_valid <= 1, go to VALID. Otherwise stay.
  - VALID: out_valid = 1 and out_data held constant. When out_ready = 1, on that edge: out_valid <= 0, ack_tgl <= ~ack_tgl, event_count <= event_count + 1, go to IDLE.
- Latency:
  - req_tgl first sampled at edge k gives out_valid = 1 after edge k+SYNC_STAGES.
  - With SYNC_STAGES = 2 and out_ready held high, ack_tgl inverts after edge k+3.
  - Minimum full round trip per transfer inside this block: SYNC_STAGES+1 cycles.
- Back-to-back: a new request seen in IDLE on the cycle right after the ack edge is accepted normally. There are no bubbles beyond the FSM.
- Overrun:
  - Set when state = VALID and req_sync != req_seen, i.e. a second inversion arrived before ack.
  - Sticky until reset.
  - The extra inversion is not lost as a level. After the ack, IDLE compares req_sync to req_seen again:
    - an odd number of extra inversions yields exactly one further transfer;
    - an even number yields none.
  - This is documented protocol-violation behaviour.
- event_count wraps from 2^CNT_W-1 to 0 with no flag.
- Glitch rule: req_tgl pulses shorter than one clock period may be missed. The initiator must hold each level for at least SYNC_STAGES+1 cycles.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset check: reset = 1 for 7 ns, then 0, with req_tgl = 0 -> ack_tgl = 0, out_valid = 0, event_count = 0, overrun = 0, and no activity for 10 cycles.
- Single transfer: 10 ns clock, SYNC_STAGES = 2, out_ready = 1. req_data = 8'hA5, req_tgl 0->1 before edge k -> out_valid = 1 and out_data = A5 after edge k+2; ack_tgl = 1 and event_count = 1 after edge k+3.
- Backpressure: out_ready = 0 for 5 cycles after out_valid rises -> out_valid and out_data = A5 held, ack_tgl unchanged. Raise out_ready -> ack inverts on that edge and out_valid drops.
- Overrun: with out_ready = 0, toggle req_tgl twice more (4 cycles apart) while in VALID -> overrun = 1 and stays 1.
  - Release out_ready -> exactly one ack inversion; event_count advances by 1 only (even extra toggles).
- Wrap: CNT_W = 2, run 5 transfers -> event_count goes 1, 2, 3, 0, 1, and ack_tgl ends at 1.
- Mid-transfer reset: assert reset while in VALID -> out_valid, ack_tgl and event_count go to 0 immediately, before the next clock edge.
  - After release, with req_tgl = 0 and initiator also reset -> no spurious transfer.
